// File: rtl/npu_mem_pkg.sv
// npu_mem_pkg: shared definitions for the NPU weight/image RAM load and readback paths.
// Contents: memory geometry defaults, port-B address widths, readback start command,
//           readback FSM state enum and the section tag carried with in-flight reads.
package npu_mem_pkg;

  localparam int IMG_WORDS   = 225;
  localparam int CONV_BYTES  = 18816;
  localparam int DENSE_WORDS = 4203;

  localparam int IMG_AW   = 10;
  localparam int CONV_AW  = 15;
  localparam int DENSE_AW = 15;

  localparam logic [31:0] START_CMD = 32'h0000_0002;

  typedef enum logic [2:0] {
    RB_IDLE,
    RB_RD_IMAGE,
    RB_RD_CONV,
    RB_RD_DENSE,
    RB_DONE
  } rb_state_e;

  // Which RAM group a returning read came from.
  typedef enum logic [1:0] {
    SEC_IMG,
    SEC_CONV,
    SEC_DENSE
  } rb_sec_e;

endpackage

// File: rtl/rb_fifo2.sv
// rb_fifo2: 2-entry synchronous FIFO, 32-bit, head visible on dat_o while count_o != 0.
// Ports: clk_i, rst_ni (sync active-low), push_i/dat_i write side, pop_i read side,
//        dat_o head word, count_o occupancy (0..2). Push into a full FIFO is the caller's bug.
module rb_fifo2 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic [31:0] dat_i,
  input  logic        pop_i,
  output logic [31:0] dat_o,
  output logic [1:0]  count_o
);

  logic [31:0] mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign dat_o   = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/memory_readback.sv
// memory_readback: sweeps port B of image(4), conv(1), dense(4) RAMs in load order and
// streams packed 32-bit words over rd_valid/rd_ready. Ports: clk, reset_n, control_reg,
// q_* read data, *_ram_addr_b read addresses, rd_valid/rd_ready/readdata, busy, done, checksum.
// Optional macro READBACK_CHECKSUM_EN: checksum = wrapping sum of accepted words, else 0.
module memory_readback
  import npu_mem_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         control_reg,
  input  logic [7:0]          q_image0,
  input  logic [7:0]          q_image1,
  input  logic [7:0]          q_image2,
  input  logic [7:0]          q_image3,
  input  logic [7:0]          q_conv,
  input  logic [7:0]          q_dense0,
  input  logic [7:0]          q_dense1,
  input  logic [7:0]          q_dense2,
  input  logic [7:0]          q_dense3,
  output logic [IMG_AW-1:0]   image_ram_addr_b,
  output logic [CONV_AW-1:0]  conv_ram_addr_b,
  output logic [DENSE_AW-1:0] dense_ram_addr_b,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [31:0]         readdata,
  output logic                busy,
  output logic                done,
  output logic [31:0]         checksum
);

  localparam logic [IMG_AW-1:0]   IMG_LAST   = IMG_AW'(IMG_WORDS - 1);
  localparam logic [CONV_AW-1:0]  CONV_LAST  = CONV_AW'(CONV_BYTES - 1);
  localparam logic [DENSE_AW-1:0] DENSE_LAST = DENSE_AW'(DENSE_WORDS - 1);

  rb_state_e           state_q, state_d;
  logic [IMG_AW-1:0]   img_addr_q, img_addr_d;
  logic [CONV_AW-1:0]  conv_addr_q, conv_addr_d;
  logic [DENSE_AW-1:0] dense_addr_q, dense_addr_d;
  logic                dense_all_q, dense_all_d;   // last dense read already issued
  logic [1:0]          infl_q, infl_d;             // words reserved but not yet pushed
  logic                pend_q, pend_d;             // a read returns data this cycle
  rb_sec_e             pend_sec_q, pend_sec_d;
  logic [1:0]          pend_byte_q, pend_byte_d;
  logic [23:0]         acc_q, acc_d;               // first three bytes of a conv word

  logic        push, pop, room, start_word;
  logic [31:0] push_dat;
  logic [1:0]  fifo_cnt;

  rb_fifo2 u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .dat_i   (push_dat),
    .pop_i   (pop),
    .dat_o   (readdata),
    .count_o (fifo_cnt)
  );

  assign rd_valid = (fifo_cnt != 2'd0);
  assign pop      = rd_valid && rd_ready;
  // A new word may only be started when it is guaranteed a FIFO slot.
  assign room     = ({1'b0, fifo_cnt} + {1'b0, infl_q}) < 3'd2;

  always_comb begin
    state_d      = state_q;
    img_addr_d   = img_addr_q;
    conv_addr_d  = conv_addr_q;
    dense_addr_d = dense_addr_q;
    dense_all_d  = dense_all_q;
    pend_d       = 1'b0;
    pend_sec_d   = pend_sec_q;
    pend_byte_d  = pend_byte_q;
    acc_d        = acc_q;
    start_word   = 1'b0;
    push         = 1'b0;
    push_dat     = '0;

    // Return path: data for the read issued last cycle.
    if (pend_q) begin
      unique case (pend_sec_q)
        SEC_IMG: begin
          push     = 1'b1;
          push_dat = {q_image0, q_image1, q_image2, q_image3};
        end
        SEC_CONV: begin
          if (pend_byte_q == 2'd3) begin
            push     = 1'b1;
            push_dat = {acc_q, q_conv};
          end else begin
            acc_d = {acc_q[15:0], q_conv};
          end
        end
        default: begin
          push     = 1'b1;
          push_dat = {q_dense0, q_dense1, q_dense2, q_dense3};
        end
      endcase
    end

    unique case (state_q)
      RB_IDLE: begin
        if (control_reg == START_CMD) state_d = RB_RD_IMAGE;
      end
      RB_RD_IMAGE: begin
        if (room) begin
          start_word = 1'b1;
          pend_d     = 1'b1;
          pend_sec_d = SEC_IMG;
          if (img_addr_q == IMG_LAST) begin
            img_addr_d = '0;
            state_d    = RB_RD_CONV;
          end else begin
            img_addr_d = img_addr_q + 1'b1;
          end
        end
      end
      RB_RD_CONV: begin
        // Bytes 1..3 of a word ride on the reservation taken by byte 0.
        if (conv_addr_q[1:0] != 2'd0 || room) begin
          start_word  = (conv_addr_q[1:0] == 2'd0);
          pend_d      = 1'b1;
          pend_sec_d  = SEC_CONV;
          pend_byte_d = conv_addr_q[1:0];
          if (conv_addr_q == CONV_LAST) begin
            conv_addr_d = '0;
            state_d     = RB_RD_DENSE;
          end else begin
            conv_addr_d = conv_addr_q + 1'b1;
          end
        end
      end
      RB_RD_DENSE: begin
        if (!dense_all_q && room) begin
          start_word = 1'b1;
          pend_d     = 1'b1;
          pend_sec_d = SEC_DENSE;
          if (dense_addr_q == DENSE_LAST) dense_all_d  = 1'b1;
          else                            dense_addr_d = dense_addr_q + 1'b1;
        end
        // Everything issued and pushed; the sole buffered word is the last one.
        if (dense_all_q && infl_q == 2'd0 && fifo_cnt == 2'd1 && pop) begin
          state_d      = RB_DONE;
          dense_addr_d = '0;
          dense_all_d  = 1'b0;
        end
      end
      RB_DONE: begin
        if (control_reg != START_CMD) state_d = RB_IDLE;
      end
      default: state_d = RB_IDLE;
    endcase

    infl_d = infl_q + {1'b0, start_word} - {1'b0, push};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= RB_IDLE;
      img_addr_q   <= '0;
      conv_addr_q  <= '0;
      dense_addr_q <= '0;
      dense_all_q  <= 1'b0;
      infl_q       <= 2'd0;
      pend_q       <= 1'b0;
      pend_sec_q   <= SEC_IMG;
      pend_byte_q  <= 2'd0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      img_addr_q   <= img_addr_d;
      conv_addr_q  <= conv_addr_d;
      dense_addr_q <= dense_addr_d;
      dense_all_q  <= dense_all_d;
      infl_q       <= infl_d;
      pend_q       <= pend_d;
      pend_sec_q   <= pend_sec_d;
      pend_byte_q  <= pend_byte_d;
      acc_q        <= acc_d;
    end
  end

  assign image_ram_addr_b = img_addr_q;
  assign conv_ram_addr_b  = conv_addr_q;
  assign dense_ram_addr_b = dense_addr_q;
  assign busy = (state_q == RB_RD_IMAGE) || (state_q == RB_RD_CONV) ||
                (state_q == RB_RD_DENSE) || rd_valid;
  assign done = (state_q == RB_DONE);

`ifdef READBACK_CHECKSUM_EN
  logic [31:0] cks_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cks_q <= '0;
    end else if (state_q == RB_IDLE && state_d == RB_RD_IMAGE) begin
      cks_q <= '0;
    end else if (pop && state_q != RB_DONE) begin
      cks_q <= cks_q + readdata;
    end
  end
  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_memory_readback.sv
// tb_memory_readback: drives memory_readback against bench-side RAM images and checks the
// streamed words, handshake/status outputs and checksum against an expected word list
// built directly from the section layout and packing rules.
module tb_memory_readback;

  localparam int NI = 225;
  localparam int NC = 18816;
  localparam int ND = 4203;
  localparam int TOTAL = NI + NC / 4 + ND;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] control_reg;
  logic [7:0]  q_image0, q_image1, q_image2, q_image3, q_conv;
  logic [7:0]  q_dense0, q_dense1, q_dense2, q_dense3;
  logic [9:0]  image_ram_addr_b;
  logic [14:0] conv_ram_addr_b, dense_ram_addr_b;
  logic        rd_valid, rd_ready, busy, done;
  logic [31:0] readdata, checksum;

  memory_readback dut (
    .clk(clk), .reset_n(reset_n), .control_reg(control_reg),
    .q_image0(q_image0), .q_image1(q_image1), .q_image2(q_image2), .q_image3(q_image3),
    .q_conv(q_conv),
    .q_dense0(q_dense0), .q_dense1(q_dense1), .q_dense2(q_dense2), .q_dense3(q_dense3),
    .image_ram_addr_b(image_ram_addr_b), .conv_ram_addr_b(conv_ram_addr_b),
    .dense_ram_addr_b(dense_ram_addr_b),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .readdata(readdata),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [7:0]  img_m   [4][NI];
  logic [7:0]  conv_m  [NC];
  logic [7:0]  dense_m [4][ND];
  logic [31:0] exp_w   [TOTAL];

  int          nchk = 0;
  int          nerr = 0;
  int          idx = 0;
  int          rises = 0;
  int          mode = 0;      // 0: ready low, 1: random 30% high, 2: ready high
  bit          chk_en = 0;
  bit          prev_done = 0;
  logic [31:0] msum = '0;
  logic [31:0] total_sum;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (word idx %0d, t=%0t)", nm, act, expv, idx, $time);
    end
  endtask

  // RAM models: one cycle read latency.
  function automatic logic [7:0] img_rd(int b, int a);
    return (a < NI) ? img_m[b][a] : 8'h00;
  endfunction
  function automatic logic [7:0] dense_rd(int b, int a);
    return (a < ND) ? dense_m[b][a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    q_image0 <= img_rd(0, int'(image_ram_addr_b));
    q_image1 <= img_rd(1, int'(image_ram_addr_b));
    q_image2 <= img_rd(2, int'(image_ram_addr_b));
    q_image3 <= img_rd(3, int'(image_ram_addr_b));
    q_conv   <= (int'(conv_ram_addr_b) < NC) ? conv_m[int'(conv_ram_addr_b)] : 8'h00;
    q_dense0 <= dense_rd(0, int'(dense_ram_addr_b));
    q_dense1 <= dense_rd(1, int'(dense_ram_addr_b));
    q_dense2 <= dense_rd(2, int'(dense_ram_addr_b));
    q_dense3 <= dense_rd(3, int'(dense_ram_addr_b));
  end

  // Consumer ready.
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1)      rd_ready = ($urandom_range(99) < 30);
      else if (mode == 2) rd_ready = 1'b1;
      else                rd_ready = 1'b0;
    end
  end

  // Compare process: sampled at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      chk("addr_range", {31'd0, (int'(image_ram_addr_b) < NI) && (int'(conv_ram_addr_b) < NC) &&
                                (int'(dense_ram_addr_b) < ND)}, 32'd1);
      if (busy || done) begin
`ifdef READBACK_CHECKSUM_EN
        chk("checksum", checksum, msum);
`else
        chk("checksum", checksum, 32'd0);
`endif
      end
      if (done) begin
        chk("done_no_valid", {31'd0, rd_valid}, 32'd0);
        chk("done_addrs", {7'd0, image_ram_addr_b, conv_ram_addr_b} | {17'd0, dense_ram_addr_b}, 32'd0);
        if (!prev_done) begin
          rises++;
          chk("done_after_last", idx, TOTAL);
        end
      end
      if (rd_valid && rd_ready) begin
        if (idx < TOTAL) chk("word", readdata, exp_w[idx]);
        else             chk("extra_word", idx, TOTAL - 1);
        if (idx == 0)    chk("lit_first_img", readdata, 32'h00010203);
        if (idx == 224)  chk("lit_last_img", readdata, 32'hE0E1E2E3);
        if (idx == 225)  chk("lit_first_conv", readdata, 32'h00010203);
        if (idx == 4928) chk("lit_last_conv", readdata, 32'h7C7D7E7F);
        msum = msum + readdata;
        idx++;
      end
      prev_done = done;
    end
  end

  task automatic start_sweep(input int m);
    idx = 0;
    rises = 0;
    msum = '0;
    prev_done = 0;
    mode = m;
    chk_en = 1;
    control_reg = 32'h0000_0002;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({nm, "_timeout"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    control_reg = '0;

    // Memory images.
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < NI; a++) img_m[b][a] = 8'((a + b) & 8'hFF);
    for (int a = 0; a < NC; a++) conv_m[a] = 8'(a & 8'hFF);
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < ND; a++) dense_m[b][a] = 8'($urandom);

    // Expected stream straight from the layout rules.
    for (int a = 0; a < NI; a++) exp_w[a] = {img_m[0][a], img_m[1][a], img_m[2][a], img_m[3][a]};
    for (int k = 0; k < NC / 4; k++)
      exp_w[NI + k] = {conv_m[4*k], conv_m[4*k+1], conv_m[4*k+2], conv_m[4*k+3]};
    for (int a = 0; a < ND; a++)
      exp_w[NI + NC/4 + a] = {dense_m[0][a], dense_m[1][a], dense_m[2][a], dense_m[3][a]};
    total_sum = '0;
    for (int i = 0; i < TOTAL; i++) total_sum = total_sum + exp_w[i];

    // Hand-computed anchors for the model itself.
    chk("model_w0", exp_w[0], 32'h00010203);
    chk("model_w224", exp_w[224], 32'hE0E1E2E3);
    chk("model_w4928", exp_w[4928], 32'h7C7D7E7F);
    chk("model_total", TOTAL, 9132);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addrs", {7'd0, image_ram_addr_b, conv_ram_addr_b} | {17'd0, dense_ram_addr_b}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Sweep 1: random backpressure.
    start_sweep(1);
    wait_done("sweep1", 60000);
    chk("sweep1_count", idx, TOTAL);
    chk("sweep1_rises", rises, 1);
    chk("sweep1_busy", {31'd0, busy}, 32'd0);
`ifdef READBACK_CHECKSUM_EN
    chk("sweep1_sum", checksum, total_sum);
`else
    chk("sweep1_sum", checksum, 32'd0);
`endif

    // Held start command must not restart.
    mode = 2;
    repeat (20) @(posedge clk);
    #1;
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_count", idx, TOTAL);
    chk("hold_rises", rises, 1);

    control_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Sweep 2: interrupted by reset at word 5000.
    start_sweep(2);
    begin
      int n;
      n = 0;
      while (idx < 5000 && n < 30000) begin
        @(posedge clk);
        n++;
      end
    end
    #1;
    chk("sweep2_reach5000", {31'd0, idx >= 5000}, 32'd1);
    chk_en = 0;
    reset_n = 1'b0;
    control_reg = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("midrst_valid", {31'd0, rd_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_addrs", {7'd0, image_ram_addr_b, conv_ram_addr_b} | {17'd0, dense_ram_addr_b}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_busy", {31'd0, busy}, 32'd0);

    // Sweep 3: full restart, must reproduce the sequence from word 0.
    start_sweep(2);
    wait_done("sweep3", 30000);
    chk("sweep3_count", idx, TOTAL);
    chk("sweep3_rises", rises, 1);
`ifdef READBACK_CHECKSUM_EN
    chk("sweep3_sum", checksum, total_sum);
`else
    chk("sweep3_sum", checksum, 32'd0);
`endif
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
